// File: rtl/nem_seq_pkg.sv
// Shared definitions for the NEM relay mux select sequencer.
//   state_t  : sequencer states
//   MAX_N    : widest supported relay bank
//   onehot() : binary index -> one-hot vector (all zero when idx >= n)
//   tw_calc(): timer width able to hold the longer of the two waits
package nem_seq_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    RELEASE = 2'd2,
    ACTUATE = 2'd3
  } state_t;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n) v = MAX_N'(1) << idx;
    return v;
  endfunction

  function automatic int tw_calc(input int t_rel, input int t_act);
    return $clog2((t_rel > t_act) ? t_rel : t_act) + 1;
  endfunction

endpackage

// File: rtl/nem_dly_cnt.sv
// Loadable down-counter used to time the relay release/actuation waits.
//   CLK    : clock, rising edge
//   RST    : asynchronous active-high reset, count <- RST_VAL
//   LD     : load LD_VAL this cycle (has priority over counting)
//   LD_VAL : value to load
//   ZERO   : count has reached zero (counter holds at zero)
module nem_dly_cnt
  #(parameter int W = 4,
    parameter logic [W-1:0] RST_VAL = '0)
  (input  logic         CLK,
   input  logic         RST,
   input  logic         LD,
   input  logic [W-1:0] LD_VAL,
   output logic         ZERO);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             cnt <= RST_VAL;
    else if (LD)         cnt <= LD_VAL;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign ZERO = (cnt == '0);

endmodule

// File: rtl/nem_ohmux_sel_seq.sv
// Select driver for a one-hot NEM relay mux bank. Turns a binary select
// request into a one-hot S vector with break-before-make sequencing:
// release the old relay, wait T_REL, actuate the new one, wait T_ACT,
// then flag SETTLED. S is never driven with two bits high.
//   CLK/RST  : clock / asynchronous active-high reset
//   REQ_VLD  : request valid; REQ_RDY: accepting (IDLE only)
//   REQ_SEL  : binary input index; REQ_OFF: deselect all
//   S        : one-hot or all-zero relay select
//   SETTLED  : S stable, mux output valid
//   BUSY     : release/actuate sequence in progress (also during INIT)
//   ERR      : one-cycle pulse when an out-of-range index is rejected
module nem_ohmux_sel_seq
  import nem_seq_pkg::*;
  #(parameter int N_IN  = 2,
    parameter int T_REL = 4,
    parameter int T_ACT = 6,
    localparam int SW   = (N_IN > 2) ? $clog2(N_IN) : 1)
  (input  logic            CLK,
   input  logic            RST,
   input  logic            REQ_VLD,
   output logic            REQ_RDY,
   input  logic [SW-1:0]   REQ_SEL,
   input  logic            REQ_OFF,
   output logic [N_IN-1:0] S,
   output logic            SETTLED,
   output logic            BUSY,
   output logic            ERR);

  localparam int TW = tw_calc(T_REL, T_ACT);

  state_t            state, state_n;
  logic [N_IN-1:0]   s_q, s_n;
  logic              settled_q, settled_n;
  logic              rdy_q, rdy_n;
  logic              busy_q, busy_n;
  logic              err_n;
  logic              err_q;
  logic [SW-1:0]     tgt_idx, tgt_idx_n;
  logic              tgt_off, tgt_off_n;
  logic              ld;
  logic [TW-1:0]     ld_val;
  logic              tmr_zero;
  logic [N_IN-1:0]   req_vec;
  logic [N_IN-1:0]   tgt_vec;
  logic              req_bad;

  // Timer starts loaded with the release wait: relay position is unknown
  // after reset, so INIT holds S low for a full release time.
  nem_dly_cnt #(.W(TW), .RST_VAL(TW'(T_REL - 1))) u_dly (
    .CLK    (CLK),
    .RST    (RST),
    .LD     (ld),
    .LD_VAL (ld_val),
    .ZERO   (tmr_zero)
  );

  assign req_bad = !REQ_OFF && (32'(REQ_SEL) >= 32'(N_IN));
  assign req_vec = REQ_OFF ? '0 : N_IN'(onehot(32'(REQ_SEL), N_IN));
  assign tgt_vec = N_IN'(onehot(32'(tgt_idx), N_IN));

  always_comb begin
    state_n   = state;
    s_n       = s_q;
    settled_n = settled_q;
    rdy_n     = rdy_q;
    busy_n    = busy_q;
    err_n     = 1'b0;
    tgt_idx_n = tgt_idx;
    tgt_off_n = tgt_off;
    ld        = 1'b0;
    ld_val    = '0;
    case (state)
      INIT: begin
        if (tmr_zero) begin
          state_n   = IDLE;
          settled_n = 1'b1;
          rdy_n     = 1'b1;
          busy_n    = 1'b0;
        end
      end
      IDLE: begin
        if (REQ_VLD && rdy_q) begin
          if (req_bad) begin
            err_n = 1'b1;
          end else begin
            tgt_idx_n = REQ_SEL;
            tgt_off_n = REQ_OFF;
            // Requesting the current position needs no relay movement.
            if (req_vec != s_q) begin
              settled_n = 1'b0;
              rdy_n     = 1'b0;
              busy_n    = 1'b1;
              ld        = 1'b1;
              if (s_q != '0) begin
                // Break first: drop the active relay before making the new one.
                s_n     = '0;
                state_n = RELEASE;
                ld_val  = TW'(T_REL - 1);
              end else begin
                s_n     = req_vec;
                state_n = ACTUATE;
                ld_val  = TW'(T_ACT - 1);
              end
            end
          end
        end
      end
      RELEASE: begin
        if (tmr_zero) begin
          if (tgt_off) begin
            state_n   = IDLE;
            settled_n = 1'b1;
            rdy_n     = 1'b1;
            busy_n    = 1'b0;
          end else begin
            s_n     = tgt_vec;
            state_n = ACTUATE;
            ld      = 1'b1;
            ld_val  = TW'(T_ACT - 1);
          end
        end
      end
      ACTUATE: begin
        if (tmr_zero) begin
          state_n   = IDLE;
          settled_n = 1'b1;
          rdy_n     = 1'b1;
          busy_n    = 1'b0;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= INIT;
      s_q       <= '0;
      settled_q <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
      tgt_idx   <= '0;
      tgt_off   <= 1'b1;
    end else begin
      state     <= state_n;
      s_q       <= s_n;
      settled_q <= settled_n;
      rdy_q     <= rdy_n;
      busy_q    <= busy_n;
      err_q     <= err_n;
      tgt_idx   <= tgt_idx_n;
      tgt_off   <= tgt_off_n;
    end
  end

  assign S       = s_q;
  assign SETTLED = settled_q;
  assign REQ_RDY = rdy_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_seq.sv
// Scoreboard bench for nem_ohmux_sel_seq: stimulus pushes the expected
// settled S value and accept-to-SETTLED latency; a monitor pops an entry on
// every SETTLED rising edge. A second instance with N_IN=3 covers ERR.
module tb_nem_ohmux_sel_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       vld, rdy, sel, off, settled, busy, err;
  logic [1:0] s;
  logic       vld3, rdy3, off3, settled3, busy3, err3;
  logic [1:0] sel3;
  logic [2:0] s3;

  nem_ohmux_sel_seq #(.N_IN(2), .T_REL(4), .T_ACT(6)) u0 (
    .CLK(clk), .RST(rst), .REQ_VLD(vld), .REQ_RDY(rdy), .REQ_SEL(sel),
    .REQ_OFF(off), .S(s), .SETTLED(settled), .BUSY(busy), .ERR(err));

  nem_ohmux_sel_seq #(.N_IN(3), .T_REL(4), .T_ACT(6)) u3 (
    .CLK(clk), .RST(rst), .REQ_VLD(vld3), .REQ_RDY(rdy3), .REQ_SEL(sel3),
    .REQ_OFF(off3), .S(s3), .SETTLED(settled3), .BUSY(busy3), .ERR(err3));

  typedef struct {
    logic [1:0] s;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_settle = 0;
  logic prev_settled = 1'b0;
  logic [1:0] prev_s = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on SETTLED rising.
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(s)), 1);
    check("no_direct_switch", 32'(prev_s != 2'b00 && s != 2'b00 && s != prev_s), 0);
    check("no_err_u0", 32'(err), 0);
    if (settled && !prev_settled) begin
      last_settle <= cyc;
      if (q.size() == 0) begin
        check("unexpected_settle", 1, 0);
      end else begin
        check({q[0].name, "_s"}, 32'(s), 32'(q[0].s));
        check({q[0].name, "_lat"}, cyc - q[0].acc, q[0].lat);
        check({q[0].name, "_busy"}, 32'(busy), 0);
        void'(q.pop_front());
      end
    end
    prev_settled <= settled;
    prev_s       <= s;
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic sel_i, input logic off_i, input logic expect_i,
                      input logic [1:0] exp_s, input int lat, input string name,
                      output int acc);
    int n;
    exp_t e;
    vld = 1'b1; sel = sel_i; off = off_i;
    n = 0;
    while (!rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rdy"}, 32'(rdy), 1);
    acc = cyc + 1;
    if (expect_i) begin
      e.s = exp_s; e.lat = lat; e.acc = acc; e.name = name;
      q.push_back(e);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  function automatic int lat_for(input int cur, input int t);
    if (t == cur) return 0;
    if (cur < 0)  return 6;
    if (t < 0)    return 4;
    return 10;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, acc2, n, cur, t, lat;
    exp_t e;
    vld = 1'b0; sel = 1'b0; off = 1'b0;
    vld3 = 1'b0; sel3 = 2'd0; off3 = 1'b0;

    // Reset: 3 cycles, then a 4-cycle INIT hold.
    #2 rst = 1'b1;
    #1;
    check("rst_s", 32'(s), 0);
    check("rst_settled", 32'(settled), 0);
    check("rst_rdy", 32'(rdy), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_err", 32'(err), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e.s = 2'b00; e.lat = 4; e.acc = cyc; e.name = "init";
    q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("init_rdy", 32'(rdy), 0);
      check("init_s", 32'(s), 0);
    end
    wait_idle();
    check("idle_rdy", 32'(rdy), 1);
    cur = -1;

    // Off to input 1.
    send(1'b1, 1'b0, 1'b1, 2'b10, 6, "off_to_1", acc);
    check("o2i_s", 32'(s), 32'b10);
    check("o2i_busy", 32'(busy), 1);
    check("o2i_rdy", 32'(rdy), 0);
    wait_idle();

    // Input 1 to input 0: 4 cycles all-low, then 01.
    send(1'b0, 1'b0, 1'b1, 2'b01, 10, "1_to_0", acc);
    n = 0;
    while (s == 2'b00 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("rel_len", n, 4);
    check("act_s", 32'(s), 32'b01);
    wait_idle();

    // Same select again: no sequence.
    send(1'b0, 1'b0, 1'b0, 2'b01, 0, "same", acc);
    check("same_settled", 32'(settled), 1);
    check("same_busy", 32'(busy), 0);
    check("same_rdy", 32'(rdy), 1);
    check("same_s", 32'(s), 32'b01);

    // Index to off, then off while already off.
    send(1'b0, 1'b1, 1'b1, 2'b00, 4, "to_off", acc);
    wait_idle();
    send(1'b1, 1'b1, 1'b0, 2'b00, 0, "off_off", acc);
    check("offoff_settled", 32'(settled), 1);
    check("offoff_busy", 32'(busy), 0);
    check("offoff_s", 32'(s), 0);

    // Backpressure: second request held until the first settles.
    send(1'b1, 1'b0, 1'b1, 2'b10, 6, "bp_first", acc);
    send(1'b0, 1'b0, 1'b1, 2'b01, 10, "bp_second", acc2);
    check("bp_accept_cycle", acc2, last_settle + 1);
    wait_idle();
    cur = 0;

    // Out-of-range select on the 3-input instance.
    vld3 = 1'b1; sel3 = 2'd2; off3 = 1'b0;
    @(negedge clk);
    vld3 = 1'b0;
    check("u3_act_s", 32'(s3), 32'b100);
    for (int i = 0; i < 20 && !settled3; i++) @(negedge clk);
    check("u3_settled", 32'(settled3), 1);
    vld3 = 1'b1; sel3 = 2'd3;
    @(negedge clk);
    vld3 = 1'b0;
    check("u3_err_pulse", 32'(err3), 1);
    check("u3_err_s", 32'(s3), 32'b100);
    check("u3_err_settled", 32'(settled3), 1);
    check("u3_err_busy", 32'(busy3), 0);
    @(negedge clk);
    check("u3_err_clear", 32'(err3), 0);
    check("u3_err_s2", 32'(s3), 32'b100);

    // Random traffic against the latency model.
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 2);
      t = (n == 2) ? -1 : n;
      lat = lat_for(cur, t);
      send(t == 1, t < 0, lat != 0, (t < 0) ? 2'b00 : ((t == 1) ? 2'b10 : 2'b01),
           lat, "rand", acc);
      cur = t;
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();

    // Reset during ACTUATE.
    if (cur != -1) begin
      send(1'b0, 1'b1, 1'b1, 2'b00, 4, "pre_rst_off", acc);
      wait_idle();
    end
    send(1'b1, 1'b0, 1'b0, 2'b10, 0, "abort", acc);
    @(negedge clk);
    check("abort_s_before", 32'(s), 32'b10);
    #1 rst = 1'b1;
    #1;
    check("abort_s", 32'(s), 0);
    check("abort_settled", 32'(settled), 0);
    check("abort_busy", 32'(busy), 1);
    check("abort_rdy", 32'(rdy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e.s = 2'b00; e.lat = 4; e.acc = cyc; e.name = "reinit";
    q.push_back(e);
    wait_idle();
    check("reinit_s", 32'(s), 0);
    check("reinit_rdy", 32'(rdy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
